// File: rtl/dma_pcie_mdma_c2h_pkt_gen.sv
// C2H packetizer: frames a raw beat stream into MDMA C2H packets (tlast/mty/ctrl) behind a 2-entry skid buffer.
// Optional per-byte odd parity output c2h_dpar when MDMA_C2H_PKT_PARITY_EN is defined.
module dma_pcie_mdma_c2h_pkt_gen #(
    parameter int DATA_W = 512,
    parameter int QID_W  = 11,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 32
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [QID_W-1:0]  cmd_qid,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] din_tdata,
    input  logic              din_tvalid,
    output logic              din_tready,
    output logic [DATA_W-1:0] c2h_tdata,
    output logic [QID_W-1:0]  c2h_ctrl_qid,
    output logic [LEN_W-1:0]  c2h_ctrl_len,
    output logic              c2h_ctrl_zero_byte,
    output logic              c2h_tlast,
    output logic [5:0]        c2h_mty,
    output logic              c2h_tvalid,
    input  logic              c2h_tready,
    output logic [CNT_W-1:0]  pkt_done_cnt,
    output logic              busy
`ifdef MDMA_C2H_PKT_PARITY_EN
   ,output logic [DATA_W/8-1:0] c2h_dpar
`endif
);
    localparam int NB  = DATA_W / 8;
    localparam int LW1 = LEN_W + 1;

    typedef enum logic [1:0] {IDLE, ZERO, DATA} state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [QID_W-1:0]  qid;
        logic [LEN_W-1:0]  len;
        logic              zb;
        logic              last;
        logic [5:0]        mty;
`ifdef MDMA_C2H_PKT_PARITY_EN
        logic [NB-1:0]     dpar;
`endif
    } beat_t;

    state_e           state_q;
    logic [QID_W-1:0] qid_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   beats_q;
    logic [5:0]       mty_q;
    logic             rdy_en_q;
    logic [1:0]       cnt_q, cnt_d;
    beat_t            e0_q, e0_d, e1_q, e1_d;
    logic [CNT_W-1:0] done_q;

    logic [LEN_W:0] beats_w;
    logic [5:0]     mty_w;
    logic           full, last_beat, push, pop, cmd_fire;
    beat_t          pbeat;

    assign beats_w   = ({1'b0, cmd_len} + LW1'(63)) >> 6;
    assign mty_w     = 6'd0 - cmd_len[5:0];
    assign full      = (cnt_q == 2'd2);
    assign last_beat = (beats_q == LW1'(1));
    assign pop       = c2h_tvalid && c2h_tready;
    assign cmd_fire  = cmd_valid && cmd_ready;

    // The next command is taken in the same cycle the final beat is pushed so packets abut.
    always_comb begin
        push       = 1'b0;
        cmd_ready  = 1'b0;
        din_tready = rdy_en_q && (state_q == DATA) && !full;
        case (state_q)
            IDLE: cmd_ready = rdy_en_q && !full;
            ZERO: begin
                push      = !full;
                cmd_ready = !full;
            end
            DATA: begin
                push      = din_tvalid && !full;
                cmd_ready = push && last_beat;
            end
            default: ;
        endcase
    end

    always_comb begin
        pbeat     = '0;
        pbeat.qid = qid_q;
        if (state_q == ZERO) begin
            pbeat.zb   = 1'b1;
            pbeat.last = 1'b1;
        end else begin
            pbeat.data = din_tdata;
            pbeat.len  = len_q;
            pbeat.last = last_beat;
            pbeat.mty  = last_beat ? mty_q : 6'd0;
        end
`ifdef MDMA_C2H_PKT_PARITY_EN
        for (int i = 0; i < NB; i++)
            pbeat.dpar[i] = ~^pbeat.data[i*8 +: 8];
`endif
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q  <= IDLE;
            qid_q    <= '0;
            len_q    <= '0;
            beats_q  <= '0;
            mty_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (push && state_q == DATA)
                beats_q <= beats_q - LW1'(1);
            if (push && (state_q == ZERO || last_beat))
                state_q <= IDLE;
            if (cmd_fire) begin
                qid_q   <= cmd_qid;
                len_q   <= cmd_len;
                beats_q <= beats_w;
                mty_q   <= mty_w;
                state_q <= (cmd_len == '0) ? ZERO : DATA;
            end
        end
    end

    // Skid buffer: e0 is the head and drives the outputs directly.
    always_comb begin
        cnt_d = cnt_q;
        e0_d  = e0_q;
        e1_d  = e1_q;
        case (cnt_q)
            2'd0: if (push) begin
                e0_d  = pbeat;
                cnt_d = 2'd1;
            end
            2'd1: begin
                if (push && pop) e0_d = pbeat;
                else if (push) begin
                    e1_d  = pbeat;
                    cnt_d = 2'd2;
                end else if (pop) cnt_d = 2'd0;
            end
            default: if (pop) begin
                e0_d  = e1_q;
                cnt_d = 2'd1;
            end
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            cnt_q  <= '0;
            e0_q   <= '0;
            e1_q   <= '0;
            done_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            if (pop && e0_q.last)
                done_q <= done_q + CNT_W'(1);
        end
    end

    assign c2h_tvalid         = (cnt_q != 2'd0);
    assign c2h_tdata          = e0_q.data;
    assign c2h_ctrl_qid       = e0_q.qid;
    assign c2h_ctrl_len       = e0_q.len;
    assign c2h_ctrl_zero_byte = e0_q.zb;
    assign c2h_tlast          = e0_q.last;
    assign c2h_mty            = e0_q.mty;
    assign pkt_done_cnt       = done_q;
    assign busy               = (state_q != IDLE) || (cnt_q != 2'd0);
`ifdef MDMA_C2H_PKT_PARITY_EN
    assign c2h_dpar           = e0_q.dpar;
`endif

endmodule

// File: tb/tb_dma_pcie_mdma_c2h_pkt_gen.sv
// Directed bench for the C2H packetizer: per-cycle vector table plus stall, max-length and reset sequences.
module tb_dma_pcie_mdma_c2h_pkt_gen;
    localparam int DATA_W = 512;
    localparam int NB     = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0, cmd_ready;
    logic [10:0]       cmd_qid = '0;
    logic [15:0]       cmd_len = '0;
    logic [DATA_W-1:0] din_tdata = '0;
    logic              din_tvalid = 1'b0, din_tready;
    logic [DATA_W-1:0] c2h_tdata;
    logic [10:0]       c2h_ctrl_qid;
    logic [15:0]       c2h_ctrl_len;
    logic              c2h_ctrl_zero_byte, c2h_tlast, c2h_tvalid;
    logic [5:0]        c2h_mty;
    logic              c2h_tready = 1'b1;
    logic [31:0]       pkt_done_cnt;
    logic              busy;
`ifdef MDMA_C2H_PKT_PARITY_EN
    logic [NB-1:0]     c2h_dpar;
`endif

    dma_pcie_mdma_c2h_pkt_gen dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_qid(cmd_qid), .cmd_len(cmd_len),
        .din_tdata(din_tdata), .din_tvalid(din_tvalid), .din_tready(din_tready),
        .c2h_tdata(c2h_tdata), .c2h_ctrl_qid(c2h_ctrl_qid), .c2h_ctrl_len(c2h_ctrl_len),
        .c2h_ctrl_zero_byte(c2h_ctrl_zero_byte), .c2h_tlast(c2h_tlast), .c2h_mty(c2h_mty),
        .c2h_tvalid(c2h_tvalid), .c2h_tready(c2h_tready),
        .pkt_done_cnt(pkt_done_cnt), .busy(busy)
`ifdef MDMA_C2H_PKT_PARITY_EN
       ,.c2h_dpar(c2h_dpar)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic cv; logic [10:0] qid; logic [15:0] len; logic dv; logic [7:0] tag; logic trdy;
        logic e_crdy, e_drdy, e_vld, e_last; logic [5:0] e_mty; logic e_zb;
        logic [15:0] e_len; logic [10:0] e_qid; logic [7:0] e_tag; logic [31:0] e_cnt;
    } vec_t;

    function automatic vec_t v(input logic cv, input int qid, input int len, input logic dv,
                               input int tag, input logic trdy, input logic crdy, input logic drdy,
                               input logic vld, input logic last, input int mty, input logic zb,
                               input int elen, input int eqid, input int etag, input int cnt);
        vec_t r;
        r.cv = cv; r.qid = 11'(qid); r.len = 16'(len); r.dv = dv; r.tag = 8'(tag); r.trdy = trdy;
        r.e_crdy = crdy; r.e_drdy = drdy; r.e_vld = vld; r.e_last = last; r.e_mty = 6'(mty);
        r.e_zb = zb; r.e_len = 16'(elen); r.e_qid = 11'(eqid); r.e_tag = 8'(etag); r.e_cnt = 32'(cnt);
        return r;
    endfunction

    task automatic chk_quiet(input string pfx);
        chk({pfx, " tvalid"}, c2h_tvalid, 0);
        chk({pfx, " tdata"}, c2h_tdata == '0, 1);
        chk({pfx, " tlast"}, c2h_tlast, 0);
        chk({pfx, " mty"}, c2h_mty, 0);
        chk({pfx, " ctrl"}, {c2h_ctrl_qid, c2h_ctrl_len, c2h_ctrl_zero_byte}, 0);
        chk({pfx, " cmd_ready"}, cmd_ready, 0);
        chk({pfx, " din_tready"}, din_tready, 0);
        chk({pfx, " cnt"}, pkt_done_cnt, 0);
        chk({pfx, " busy"}, busy, 0);
    endtask

    vec_t tv[20];

    initial begin
        int sent, got, occ, nout, nlast, last_idx, bad_mty;
        logic [5:0] last_mty;
        logic [15:0] last_len;
        logic stall, din_fire, out_fire;
        logic [DATA_W-1:0] s_data;
        logic [5:0] s_mty;
        logic s_last;

        // tests 1-3 and a full-skid stall, one row per clock
        tv[0]  = v(0,0,0,   0,0,   1, 0,0, 0,0,0, 0,0,  0,0,   0);
        tv[1]  = v(1,5,128, 0,0,   1, 1,0, 0,0,0, 0,0,  0,0,   0);
        tv[2]  = v(0,0,0,   1,'hA1,1, 0,1, 1,0,0, 0,128,5,'hA1,0);
        tv[3]  = v(0,0,0,   1,'hA2,1, 1,1, 1,1,0, 0,128,5,'hA2,0);
        tv[4]  = v(1,7,1,   0,0,   1, 1,0, 0,0,0, 0,0,  0,0,   1);
        tv[5]  = v(1,8,100, 1,'hB1,1, 1,1, 1,1,63,0,1,  7,'hB1,1);
        tv[6]  = v(0,0,0,   1,'hB2,1, 0,1, 1,0,0, 0,100,8,'hB2,2);
        tv[7]  = v(1,9,0,   1,'hB3,1, 1,1, 1,1,28,0,100,8,'hB3,2);
        tv[8]  = v(0,0,0,   0,0,   1, 1,0, 1,1,0, 1,0,  9,0,   3);
        tv[9]  = v(0,0,0,   0,0,   1, 1,0, 0,0,0, 0,0,  0,0,   4);
        tv[10] = v(1,3,0,   1,'h77,1, 1,0, 0,0,0, 0,0,  0,0,   4);
        tv[11] = v(0,0,0,   1,'h77,1, 1,0, 1,1,0, 1,0,  3,0,   4);
        tv[12] = v(0,0,0,   0,0,   1, 1,0, 0,0,0, 0,0,  0,0,   5);
        tv[13] = v(1,1,192, 0,0,   0, 1,0, 0,0,0, 0,0,  0,0,   5);
        tv[14] = v(0,0,0,   1,'hC1,0, 0,1, 1,0,0, 0,192,1,'hC1,5);
        tv[15] = v(0,0,0,   1,'hC2,0, 0,1, 1,0,0, 0,192,1,'hC1,5);
        tv[16] = v(0,0,0,   1,'hC3,0, 0,0, 1,0,0, 0,192,1,'hC1,5);
        tv[17] = v(0,0,0,   1,'hC3,1, 0,0, 1,0,0, 0,192,1,'hC2,5);
        tv[18] = v(0,0,0,   1,'hC3,1, 1,1, 1,1,0, 0,192,1,'hC3,5);
        tv[19] = v(0,0,0,   0,0,   1, 1,0, 0,0,0, 0,0,  0,0,   6);

        repeat (3) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            cmd_valid = tv[i].cv; cmd_qid = tv[i].qid; cmd_len = tv[i].len;
            din_tvalid = tv[i].dv; din_tdata = {NB{tv[i].tag}}; c2h_tready = tv[i].trdy;
            #1;
            chk($sformatf("v%0d cmd_ready", i), cmd_ready, tv[i].e_crdy);
            chk($sformatf("v%0d din_tready", i), din_tready, tv[i].e_drdy);
            step();
            chk($sformatf("v%0d tvalid", i), c2h_tvalid, tv[i].e_vld);
            if (tv[i].e_vld) begin
                chk($sformatf("v%0d tlast", i), c2h_tlast, tv[i].e_last);
                chk($sformatf("v%0d mty", i), c2h_mty, tv[i].e_mty);
                chk($sformatf("v%0d zero_byte", i), c2h_ctrl_zero_byte, tv[i].e_zb);
                chk($sformatf("v%0d ctrl_len", i), c2h_ctrl_len, tv[i].e_len);
                chk($sformatf("v%0d ctrl_qid", i), c2h_ctrl_qid, tv[i].e_qid);
                chk($sformatf("v%0d tdata", i), c2h_tdata == {NB{tv[i].e_tag}}, 1);
            end
            chk($sformatf("v%0d cnt", i), pkt_done_cnt, tv[i].e_cnt);
        end

        // len=640 with random output stalls, scoreboarded against a bench occupancy model
        cmd_valid = 1; cmd_qid = 2; cmd_len = 640; din_tvalid = 0; c2h_tready = 1;
        step();
        cmd_valid = 0;
        sent = 0; got = 0; occ = 0; stall = 0;
        s_data = '0; s_mty = '0; s_last = 0;
        for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
            din_tvalid = (sent < 10);
            din_tdata = {NB{8'(8'h10 + sent)}};
            c2h_tready = 1'($urandom_range(0, 1));
            #1;
            chk("stall din_tready", din_tready, (sent < 10) && (occ < 2));
            chk("stall tvalid", c2h_tvalid, occ > 0);
            if (stall) chk("stall hold", {c2h_tdata == s_data, c2h_mty == s_mty, c2h_tlast == s_last}, 3'b111);
            din_fire = din_tvalid && din_tready;
            out_fire = c2h_tvalid && c2h_tready;
            if (out_fire) begin
                chk("stall order", c2h_tdata == {NB{8'(8'h10 + got)}}, 1);
                chk("stall tlast", c2h_tlast, got == 9);
                chk("stall mty", c2h_mty, 0);
                got++;
            end
            occ = occ + int'(din_fire) - int'(out_fire);
            if (din_fire) sent++;
            stall = c2h_tvalid && !c2h_tready;
            s_data = c2h_tdata; s_mty = c2h_mty; s_last = c2h_tlast;
            step();
        end
        din_tvalid = 0; c2h_tready = 1;
        chk("stall beats out", got, 10);
        chk("stall cnt", pkt_done_cnt, 7);

        // len=65535: 1024 beats, single tlast, mty=1
        cmd_valid = 1; cmd_qid = 4; cmd_len = 16'hFFFF;
        step();
        cmd_valid = 0;
        sent = 0; nout = 0; nlast = 0; last_idx = 0; bad_mty = 0; last_mty = '0; last_len = '0;
        for (int cyc = 0; cyc < 1200 && nout < 1024; cyc++) begin
            din_tvalid = (sent < 1024);
            din_tdata = {NB{8'(sent)}};
            #1;
            if (din_tvalid && din_tready) sent++;
            if (c2h_tvalid) begin
                nout++;
                if (c2h_tlast) begin
                    nlast++; last_idx = nout; last_mty = c2h_mty; last_len = c2h_ctrl_len;
                end else if (c2h_mty != 0) bad_mty++;
            end
            step();
        end
        din_tvalid = 0;
        chk("max beats", nout, 1024);
        chk("max tlast count", nlast, 1);
        chk("max tlast index", last_idx, 1024);
        chk("max mty", last_mty, 1);
        chk("max ctrl_len", last_len, 16'hFFFF);
        chk("max mid mty", bad_mty, 0);
        chk("max cnt", pkt_done_cnt, 8);

        // reset after beat 3 of 10
        cmd_valid = 1; cmd_qid = 2; cmd_len = 640;
        step();
        cmd_valid = 0;
        for (int b = 0; b < 3; b++) begin
            din_tvalid = 1; din_tdata = {NB{8'(8'h30 + b)}};
            step();
        end
        din_tvalid = 0;
        chk("pre-reset tvalid", c2h_tvalid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_quiet("midreset");
        step();
        rst_n = 1'b1;
        step();
        cmd_valid = 1; cmd_qid = 6; cmd_len = 64;
        #1;
        chk("post-reset cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 0;
        din_tvalid = 1; din_tdata = DATA_W'(1);
        step();
        din_tvalid = 0;
        chk("post-reset tvalid", c2h_tvalid, 1);
        chk("post-reset tlast", c2h_tlast, 1);
        chk("post-reset mty", c2h_mty, 0);
        chk("post-reset ctrl", {c2h_ctrl_qid, c2h_ctrl_len}, {11'd6, 16'd64});
        chk("post-reset tdata", c2h_tdata == DATA_W'(1), 1);
`ifdef MDMA_C2H_PKT_PARITY_EN
        chk("dpar", c2h_dpar, {{(NB-1){1'b1}}, 1'b0});
`endif
        step();
        chk("post-reset cnt", pkt_done_cnt, 1);
        chk("post-reset idle", {c2h_tvalid, busy}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
